// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between the IF fetch port and the MEM load/store port.
// MEM has priority; dm_run bounds how many MEM grants can pass a waiting IF request.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned MAX_DM_RUN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [CW-1:0] dm_run_q, dm_run_d;
    logic          lost_q, lost_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    logic if_elig, dm_elig, busy_req;

    // A requester whose ready is high this cycle is completing and must not be re-granted.
    assign if_elig = if_req & ~if_ready_q;
    assign dm_elig = dm_req & ~dm_ready_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        dm_run_d    = dm_run_q;
        lost_d      = lost_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        busy_req    = (state_q == BUSY_IF) ? if_req : dm_req;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    dm_run_d = '0;
                end
                if (dm_elig && !(if_elig && (dm_run_q == CW'(MAX_DM_RUN)))) begin
                    state_d     = BUSY_DM;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    lat_d       = '0;
                    lost_d      = 1'b0;
                    if (if_req && (dm_run_q != CW'(MAX_DM_RUN))) begin
                        dm_run_d = dm_run_q + CW'(1);
                    end
                end else if (if_elig) begin
                    state_d    = BUSY_IF;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    lat_d      = '0;
                    lost_d     = 1'b0;
                    dm_run_d   = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (!busy_req) begin
                    lost_d = 1'b1;
                end
                if (lat_q == CW'(RD_LAT)) begin
                    state_d = IDLE;
                    lat_d   = '0;
                    // A requester that let go at any point during the access gets no completion.
                    if (busy_req && !lost_q) begin
                        if (state_q == BUSY_IF) begin
                            if_ready_d = 1'b1;
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_ready_d = 1'b1;
                            if (!mem_we_q) begin
                                dm_rdata_d = mem_rdata;
                            end
                        end
                    end
                end else begin
                    lat_d = lat_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            dm_run_q    <= '0;
            lost_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            dm_run_q    <= dm_run_d;
            lost_q      <= lost_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers accesses, a negedge monitor
// pops expected accesses and completions, and per-scenario tasks check cycle-exact timing.
module tb_mem_port_arbiter;

    localparam int unsigned AW         = 32;
    localparam int unsigned DW         = 32;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned MAX_DM_RUN = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          if_stall;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          dm_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    acc_t          exp_acc[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_dm[$];

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [RD_LAT];
    logic          mem_en_prev = 1'b0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_DM_RUN(MAX_DM_RUN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations hold an address-derived pattern; 0x4 holds a fixed boot word.
    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h4) return 32'h8C01_0000;
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic acc_t mk_acc(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        acc_t r;
        r.addr  = a;
        r.we    = w;
        r.wdata = d;
        return r;
    endfunction

    // Memory macro: read data appears RD_LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_rd(mem_addr) : 32'hDEAD_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(negedge clk) begin
        acc_t          a;
        logic [DW-1:0] d;
        checks++;
        if (if_stall !== (if_req & ~if_ready)) begin
            errors++;
            $display("FAIL if_stall got=%b want=%b t=%0t", if_stall, if_req & ~if_ready, $time);
        end
        checks++;
        if (dm_stall !== (dm_req & ~dm_ready)) begin
            errors++;
            $display("FAIL dm_stall got=%b want=%b t=%0t", dm_stall, dm_req & ~dm_ready, $time);
        end
        if (mem_en) begin
            checks++;
            if (mem_en_prev) begin
                errors++;
                $display("FAIL mem_en_width mem_en high two cycles in a row t=%0t", $time);
            end
            checks++;
            if (exp_acc.size() == 0) begin
                errors++;
                $display("FAIL access unexpected addr=%h we=%b t=%0t", mem_addr, mem_we, $time);
            end else begin
                a = exp_acc.pop_front();
                if (mem_addr !== a.addr || mem_we !== a.we || (a.we && mem_wdata !== a.wdata)) begin
                    errors++;
                    $display("FAIL access got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h t=%0t",
                             mem_addr, mem_we, mem_wdata, a.addr, a.we, a.wdata, $time);
                end
            end
        end
        mem_en_prev = mem_en;
        if (if_ready) begin
            checks++;
            if (exp_if.size() == 0) begin
                errors++;
                $display("FAIL if_ready unexpected pulse rdata=%h t=%0t", if_rdata, $time);
            end else begin
                d = exp_if.pop_front();
                if (if_rdata !== d) begin
                    errors++;
                    $display("FAIL if_rdata got=%h want=%h t=%0t", if_rdata, d, $time);
                end
            end
        end
        if (dm_ready) begin
            checks++;
            if (exp_dm.size() == 0) begin
                errors++;
                $display("FAIL dm_ready unexpected pulse rdata=%h t=%0t", dm_rdata, $time);
            end else begin
                d = exp_dm.pop_front();
                if (dm_rdata !== d) begin
                    errors++;
                    $display("FAIL dm_rdata got=%h want=%h t=%0t", dm_rdata, d, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for if_ready; the pulse must arrive exactly want_n cycles from the call.
    task automatic wait_if_ready(input string tag, input int want_n);
        int n = 0;
        while (if_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (if_ready !== 1'b1 || n != want_n) begin
            errors++;
            $display("FAIL %s if_ready got after %0d cycles (ready=%b) want %0d", tag, n, if_ready, want_n);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            if_rdata !== '0 || dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs en=%b we=%b addr=%h wd=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        step();
        if_req  = 1'b1;
        if_addr = 32'h100;
        exp_acc.push_back(mk_acc(32'h100, 1'b0, '0));
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            if_rdata !== '0 || dm_rdata !== '0) begin
            errors++;
            $display("FAIL reset_midrun en=%b addr=%h ready=%b want all 0", mem_en, mem_addr, if_ready);
        end
        if_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d mem_en=%b want 0", c, mem_en);
            end
        end
    endtask

    task automatic test_if_read();
        if_req  = 1'b1;
        if_addr = 32'h4;
        exp_acc.push_back(mk_acc(32'h4, 1'b0, '0));
        exp_if.push_back(32'h8C01_0000);
        for (int c = 1; c <= 4; c++) begin
            step();
            checks++;
            if (mem_en !== (c == 1) || if_ready !== (c == 4) ||
                (c == 1 && mem_addr !== 32'h4) || (c == 4 && if_rdata !== 32'h8C01_0000)) begin
                errors++;
                $display("FAIL if_read cycle %0d en=%b addr=%h rdy=%b rd=%h want en=%b rdy=%b",
                         c, mem_en, mem_addr, if_ready, if_rdata, c == 1, c == 4);
            end
        end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_collision();
        logic [DW-1:0] rd8;
        rd8      = mem_rd(32'h8);
        if_req   = 1'b1;
        if_addr  = 32'h8;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h10;
        dm_wdata = 32'hDEAD_BEEF;
        exp_acc.push_back(mk_acc(32'h10, 1'b1, 32'hDEAD_BEEF));
        exp_acc.push_back(mk_acc(32'h8, 1'b0, '0));
        exp_dm.push_back('0);
        exp_if.push_back(rd8);
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (mem_en !== (c == 1 || c == 5) || dm_ready !== (c == 4) || if_ready !== (c == 8) ||
                if_stall !== (c <= 7) || (c == 1 && (mem_we !== 1'b1 || mem_addr !== 32'h10)) ||
                (c == 5 && (mem_we !== 1'b0 || mem_addr !== 32'h8))) begin
                errors++;
                $display("FAIL collision cycle %0d en=%b we=%b addr=%h dmr=%b ifr=%b ifs=%b",
                         c, mem_en, mem_we, mem_addr, dm_ready, if_ready, if_stall);
            end
            if (c == 4) dm_req = 1'b0;
        end
        if_req = 1'b0;
        step();
        if_req  = 1'b1;
        if_addr = 32'h10;
        exp_acc.push_back(mk_acc(32'h10, 1'b0, '0));
        exp_if.push_back(32'hDEAD_BEEF);
        wait_if_ready("store_readback", RD_LAT + 2);
        if_req = 1'b0;
        step();
    endtask

    // MEM keeps re-requesting after abandoning each load, so it stays eligible at every
    // arbitration point; IF must win once MAX_DM_RUN MEM grants have passed it.
    task automatic test_starvation();
        logic [AW-1:0] da;
        logic [AW-1:0] ia;
        logic          is_if;
        da      = 32'h200;
        ia      = 32'h300;
        if_req  = 1'b1;
        if_addr = ia;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = da;
        for (int s = 0; s < 2 * (MAX_DM_RUN + 1); s++) begin
            is_if = ((s % (MAX_DM_RUN + 1)) == MAX_DM_RUN);
            if (is_if) begin
                exp_acc.push_back(mk_acc(ia, 1'b0, '0));
                exp_if.push_back(mem_rd(ia));
            end else begin
                exp_acc.push_back(mk_acc(da, 1'b0, '0));
            end
            step();
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== (is_if ? ia : da)) begin
                errors++;
                $display("FAIL starve slot %0d en=%b addr=%h want en=1 addr=%h",
                         s, mem_en, mem_addr, is_if ? ia : da);
            end
            if (!is_if) dm_req = 1'b0;
            step();
            if (!is_if) begin
                da      = da + 32'h10;
                dm_addr = da;
                dm_req  = 1'b1;
            end
            repeat (2) step();
            if (is_if) begin
                checks++;
                if (if_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL starve slot %0d if_ready=%b want 1", s, if_ready);
                end
                ia      = ia + 32'h4;
                if_addr = ia;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_drop();
        logic [DW-1:0] ld;
        ld      = mem_rd(32'h50);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h50;
        exp_acc.push_back(mk_acc(32'h50, 1'b0, '0));
        exp_dm.push_back(ld);
        for (int c = 1; c <= RD_LAT + 2; c++) step();
        checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== ld) begin
            errors++;
            $display("FAIL dm_load rdy=%b rd=%h want rdy=1 rd=%h", dm_ready, dm_rdata, ld);
        end
        dm_req = 1'b0;
        step();
        dm_req  = 1'b1;
        dm_addr = 32'h60;
        exp_acc.push_back(mk_acc(32'h60, 1'b0, '0));
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 2) dm_req = 1'b0;
            if (c == 4) begin
                if_req  = 1'b1;
                if_addr = 32'h70;
                exp_acc.push_back(mk_acc(32'h70, 1'b0, '0));
                exp_if.push_back(mem_rd(32'h70));
            end
            checks++;
            if (dm_ready !== 1'b0 || dm_rdata !== ld || (c == 5 && (mem_en !== 1'b1 || mem_addr !== 32'h70))) begin
                errors++;
                $display("FAIL drop cycle %0d dmr=%b rd=%h en=%b addr=%h want dmr=0 rd=%h",
                         c, dm_ready, dm_rdata, mem_en, mem_addr, ld);
            end
        end
        wait_if_ready("after_drop", RD_LAT + 1);
        if_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_if();
        if_req  = 1'b1;
        if_addr = 32'h80;
        exp_acc.push_back(mk_acc(32'h80, 1'b0, '0));
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || if_ready !== 1'b0 || mem_addr !== '0 || if_rdata !== '0) begin
            errors++;
            $display("FAIL reset_mid_if en=%b rdy=%b addr=%h rd=%h want all 0", mem_en, if_ready, mem_addr, if_rdata);
        end
        step();
        rst_n = 1'b1;
        exp_acc.push_back(mk_acc(32'h80, 1'b0, '0));
        exp_if.push_back(mem_rd(32'h80));
        wait_if_ready("regrant_after_reset", RD_LAT + 2);
        if_req = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_collision();
        test_starvation();
        test_drop();
        test_reset_mid_if();
        checks++;
        if (exp_acc.size() != 0 || exp_if.size() != 0 || exp_dm.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left acc=%0d if=%0d dm=%0d want 0",
                     exp_acc.size(), exp_if.size(), exp_dm.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
